cpu_core: RTL

Single-cycle Hack-style CPU datapath and control that sits directly upstream of `alu`. It decodes each 16-bit instruction into the ALU control bits and operands and holds the A, D and PC registers. It also holds a carry flag and issues data-memory writes from the ALU result. Instruction and data memories are external. `cpu_core` instantiates one `alu` with `BUS_WIDTH` = 16.

---
 rtl/cpu_core_if.sv | 24 ++
 rtl/cpu_core.sv | 117 +++++++++++
 2 files changed

// File: rtl/cpu_core_if.sv
// Bus bundle between cpu_core and its instruction ROM / data RAM environment.
// The master side is the core; the slave side is the memory system or a bench.
interface cpu_core_if #(
  parameter int unsigned BUS_WIDTH = 16
);
  logic [15:0]          instr;
  logic                 instr_valid;
  logic [BUS_WIDTH-1:0] in_m;
  logic [BUS_WIDTH-1:0] out_m;
  logic                 write_m;
  logic [14:0]          address_m;
  logic [14:0]          pc;
  logic                 carry_flag;

  modport master (
    input  instr, instr_valid, in_m,
    output out_m, write_m, address_m, pc, carry_flag
  );

  modport slave (
    output instr, instr_valid, in_m,
    input  out_m, write_m, address_m, pc, carry_flag
  );
endinterface

// File: rtl/cpu_core.sv
// Single-cycle Hack-style CPU core: instruction decode, A/D/PC/carry registers
// and the Hack ALU it drives.
module alu #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] x,
  input  logic [BUS_WIDTH-1:0] y,
  input  logic                 zx,
  input  logic                 nx,
  input  logic                 zy,
  input  logic                 ny,
  input  logic                 f,
  input  logic                 no,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 zr,
  output logic                 ng,
  output logic                 carry
);
  logic [BUS_WIDTH-1:0] x_z, x_n, y_z, y_n, res;
  logic [BUS_WIDTH:0]   sum;

  always_comb begin
    x_z   = zx ? '0 : x;
    x_n   = nx ? ~x_z : x_z;
    y_z   = zy ? '0 : y;
    y_n   = ny ? ~y_z : y_z;
    sum   = {1'b0, x_n} + {1'b0, y_n};
    res   = f ? sum[BUS_WIDTH-1:0] : (x_n & y_n);
    // Carry is the adder carry-out before output negation; AND ops never carry.
    carry = f & sum[BUS_WIDTH];
    out   = no ? ~res : res;
    zr    = (out == '0);
    ng    = out[BUS_WIDTH-1];
  end
endmodule

module cpu_core #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  cpu_core_if.master bus
);
  logic [BUS_WIDTH-1:0] a_q, a_d, d_q, d_d;
  logic [14:0]          pc_q, pc_d;
  logic                 carry_q, carry_d;

  logic                 is_c, sel_m, take;
  logic [2:0]           dest, jmp;
  logic [BUS_WIDTH-1:0] alu_y, alu_out;
  logic                 alu_zr, alu_ng, alu_carry;
  logic                 unused_instr;

  assign is_c         = bus.instr[15];
  assign sel_m        = bus.instr[12];
  assign dest         = bus.instr[5:3];
  assign jmp          = bus.instr[2:0];
  assign unused_instr = ^bus.instr[14:13];
  assign alu_y        = sel_m ? bus.in_m : a_q;

  alu #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_alu (
    .x     (d_q),
    .y     (alu_y),
    .zx    (bus.instr[11]),
    .nx    (bus.instr[10]),
    .zy    (bus.instr[9]),
    .ny    (bus.instr[8]),
    .f     (bus.instr[7]),
    .no    (bus.instr[6]),
    .out   (alu_out),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .carry (alu_carry)
  );

  assign take = is_c & ((jmp[2] & alu_ng) | (jmp[1] & alu_zr) | (jmp[0] & ~alu_ng & ~alu_zr));

  always_comb begin
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    if (bus.instr_valid) begin
      if (!is_c) begin
        a_d = BUS_WIDTH'(bus.instr[14:0]);
      end else begin
        if (dest[2]) a_d = alu_out;
        if (dest[1]) d_d = alu_out;
        carry_d = alu_carry;
      end
      // Jump target is the A value held before this instruction's writeback.
      pc_d = take ? a_q[14:0] : pc_q + 15'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
    end
  end

  assign bus.out_m      = alu_out;
  assign bus.write_m    = is_c & dest[0] & bus.instr_valid & rst_n;
  assign bus.address_m  = a_q[14:0];
  assign bus.pc         = pc_q;
  assign bus.carry_flag = carry_q;
endmodule
